cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Consumer of every FU's completion request, including the pipelined mult's cdb_valid/mult_result.
//  Grants up to CDB_WIDTH FUs per cycle with rotating (round-robin) priority.
//  Grants are combinational in the same cycle so a granted FU's last stage can advance.
//  Granted packets are registered and broadcast on the CDB the next cycle to RS, map table and ROB.
// PARAMETERS
//  NUM_FU     4  number of requesting functional units (index 0..NUM_FU-1)
//  CDB_WIDTH  2  broadcast slots per cycle, 1 <= CDB_WIDTH <= NUM_FU
//  PTR_W      $clog2(NUM_FU)  width of round-robin pointer
// PORTS
//  clock        in   1                     system clock, all state on posedge
//  reset        in   1                     synchronous, active-low (0 = reset)
//  fu_req       in   NUM_FU                per-FU completion request (mult: cdb_valid)
//  fu_result    in   NUM_FU x CDB_REG_PACKET  per-FU {result, completing_reg, valid}
//  fu_gnt       out  NUM_FU                per-FU grant, same cycle as request (mult: cdb_gnt)
//  cdb_out      out  CDB_WIDTH x CDB_REG_PACKET  registered CDB broadcast
//  cdb_count    out  $clog2(CDB_WIDTH+1)   number of valid slots in cdb_out
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - all cdb_out slots: valid=0, result=0, completing_reg=0; cdb_count=0; rr_ptr=0.
//    - fu_gnt is forced to all-zero combinationally while reset==0.
//  - Eligibility: FU i is eligible iff fu_req[i]==1 AND fu_result[i].valid==1. All others are never granted.
//  - Selection (combinational):
//    - scan i = rr_ptr, rr_ptr+1, ... mod NUM_FU;
//    - grant the first min(CDB_WIDTH, #eligible) eligible FUs; fu_gnt is one-hot per granted FU.
//  - Slot assignment: k-th granted FU in scan order goes to cdb_out[k] at the next posedge.
//    Unused slots are written valid=0, result=0, completing_reg=0.
//  - Latency: request and grant in cycle N; broadcast visible in cdb_out during cycle N+1.
//    cdb_out is held for exactly one cycle and rewritten every cycle; there is no stall input.
//  - rr_ptr update at posedge:
//    - if >=1 grant: rr_ptr <= (index of last granted FU + 1) mod NUM_FU (wrap from NUM_FU-1 to 0);
//    - if no grant: rr_ptr unchanged.
//  - Fairness: a continuously eligible FU is granted within ceil(NUM_FU/CDB_WIDTH) cycles.
//  - Ungranted FUs are not latched; the FU must hold its request, and the mult holds because cdb_gnt=0.
//  - Packet contents pass through unmodified. Width of result and completing_reg are per CDB_REG_PACKET.
//  - No duplicate-tag check: distinct FUs carry distinct tags by construction.
//  - Reset mid-operation overrides any grant in flight: no cdb_out slot valid next cycle, rr_ptr=0.
//  - cdb_count = popcount of granted FUs, registered alongside cdb_out.
// TESTING
//  1. Reset: reset=0 for 2 cycles with all fu_req=1 -> fu_gnt=0000, cdb_out all valid=0, cdb_count=0;
//     first cycle after reset=1 -> fu_gnt=0011.
//  2. Single request: fu_req=0100, fu_result[2]={0xDEADBEEF, preg 17}
//     -> fu_gnt=0100; next cycle cdb_out[0]={0xDEADBEEF, 17, valid 1}, cdb_out[1].valid=0, cdb_count=1.
//  3. Round-robin: fu_req=1111 held 4 cycles, rr_ptr=0
//     -> fu_gnt 0011, 1100, 0011, 1100; cdb_out slot order follows scan order.
//  4. Wrap-around: rr_ptr=3, fu_req=1011
//     -> fu_gnt=1001, cdb_out[0]=FU3, cdb_out[1]=FU0, rr_ptr<=1.
//  5. Mult backpressure: mult (FU1) and 2 ALUs (FU0, FU2) request, rr_ptr=2
//     -> FU2,FU0 granted and mult gnt=0 with its packet held; next cycle mult granted, result 1 cycle later.
//  6. Invalid packet: fu_req[3]=1 with fu_result[3].valid=0 -> fu_gnt[3]=0, rr_ptr unchanged if no other request.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to CDB_WIDTH completing FUs per cycle with rotating
// priority and broadcasts their packets on the CDB one cycle later.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned CDB_WIDTH = 2,
  parameter int unsigned RESULT_W  = 32,
  parameter int unsigned TAG_W     = 6,
  localparam int unsigned PKT_W    = RESULT_W + TAG_W + 1,
  localparam int unsigned PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int unsigned CNT_W    = $clog2(CDB_WIDTH + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_FU-1:0]                   fu_req,
  input  logic [NUM_FU-1:0][PKT_W-1:0]        fu_result,
  output logic [NUM_FU-1:0]                   fu_gnt,
  output logic [CDB_WIDTH-1:0][PKT_W-1:0]     cdb_out,
  output logic [CNT_W-1:0]                    cdb_count
);

  localparam int unsigned SUM_W = PTR_W + 1;

  logic [PTR_W-1:0]                  rr_ptr;
  logic [PTR_W-1:0]                  ptr_next;
  logic [PTR_W-1:0]                  last_idx;
  logic [SUM_W-1:0]                  scan_sum;
  logic [NUM_FU-1:0][PTR_W-1:0]      scan_idx;
  logic [NUM_FU-1:0]                 eligible;
  logic [NUM_FU-1:0]                 gnt;
  logic [CDB_WIDTH-1:0][PTR_W-1:0]   slot_sel;
  logic [CDB_WIDTH-1:0]              slot_used;
  logic [CNT_W-1:0]                  n_gnt;

  // Scan order: rr_ptr, rr_ptr+1, ... modulo NUM_FU (NUM_FU need not be a power of two)
  always_comb begin
    scan_sum = '0;
    scan_idx = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      scan_sum = {1'b0, rr_ptr} + SUM_W'(j);
      if (scan_sum >= SUM_W'(NUM_FU)) begin
        scan_sum = scan_sum - SUM_W'(NUM_FU);
      end
      scan_idx[j] = scan_sum[PTR_W-1:0];
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      eligible[i] = fu_req[i] & fu_result[i][0];
    end
  end

  // Take the first CDB_WIDTH eligible FUs in scan order; k-th grant lands in slot k
  always_comb begin
    gnt       = '0;
    slot_sel  = '0;
    slot_used = '0;
    n_gnt     = '0;
    last_idx  = rr_ptr;
    for (int j = 0; j < NUM_FU; j++) begin
      if (eligible[scan_idx[j]] && (n_gnt < CNT_W'(CDB_WIDTH))) begin
        gnt[scan_idx[j]] = 1'b1;
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (n_gnt == CNT_W'(k)) begin
            slot_sel[k]  = scan_idx[j];
            slot_used[k] = 1'b1;
          end
        end
        n_gnt    = n_gnt + CNT_W'(1);
        last_idx = scan_idx[j];
      end
    end
  end

  always_comb begin
    ptr_next = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
    fu_gnt   = reset ? gnt : '0;
  end

  // Broadcast register: every slot is rewritten each cycle, unused slots cleared
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr    <= '0;
      cdb_out   <= '0;
      cdb_count <= '0;
    end else begin
      if (n_gnt != '0) begin
        rr_ptr <= ptr_next;
      end
      for (int k = 0; k < CDB_WIDTH; k++) begin
        cdb_out[k] <= slot_used[k] ? fu_result[slot_sel[k]] : '0;
      end
      cdb_count <= n_gnt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a scan-order model of the arbitration rules.
module tb_cdb_arbiter;

  localparam int NUM_FU    = 4;
  localparam int CDB_WIDTH = 2;
  localparam int RESULT_W  = 32;
  localparam int TAG_W     = 6;
  localparam int PKT_W     = RESULT_W + TAG_W + 1;
  localparam int CNT_W     = 2;

  typedef logic [NUM_FU-1:0][PKT_W-1:0]    pkts_t;
  typedef logic [CDB_WIDTH-1:0][PKT_W-1:0] slots_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [NUM_FU-1:0]    fu_req = '0;
  pkts_t                fu_result = '0;
  logic [NUM_FU-1:0]    fu_gnt;
  slots_t               cdb_out;
  logic [CNT_W-1:0]     cdb_count;

  int     passed = 0;
  int     total  = 0;
  int     m_ptr  = 0;
  int     m_cnt  = 0;
  slots_t m_slots = '0;
  logic   m_live = 1'b0;
  pkts_t  base;
  pkts_t  rr;

  cdb_arbiter #(
    .NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH), .RESULT_W(RESULT_W), .TAG_W(TAG_W)
  ) dut (
    .clock(clock), .reset(reset), .fu_req(fu_req), .fu_result(fu_result),
    .fu_gnt(fu_gnt), .cdb_out(cdb_out), .cdb_count(cdb_count)
  );

  always #5 clock = ~clock;

  function automatic logic [PKT_W-1:0] pkt(logic [31:0] r, logic [5:0] t, logic v);
    return {r, t, v};
  endfunction

  // Arbitration rules: walk FUs from the pointer, grant the first CDB_WIDTH eligible ones
  function automatic logic [NUM_FU-1:0] exp_gnt(int ptr, logic [NUM_FU-1:0] req, pkts_t res);
    logic [NUM_FU-1:0] g = '0;
    int taken = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      int i = (ptr + j) % NUM_FU;
      if (req[i] && res[i][0] && taken < CDB_WIDTH) begin
        g[i] = 1'b1;
        taken++;
      end
    end
    return g;
  endfunction

  function automatic slots_t exp_slots(int ptr, logic [NUM_FU-1:0] req, pkts_t res);
    slots_t s = '0;
    int taken = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      int i = (ptr + j) % NUM_FU;
      if (req[i] && res[i][0] && taken < CDB_WIDTH) begin
        s[taken] = res[i];
        taken++;
      end
    end
    return s;
  endfunction

  function automatic int exp_ptr(int ptr, logic [NUM_FU-1:0] req, pkts_t res);
    int last = -1;
    int taken = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      int i = (ptr + j) % NUM_FU;
      if (req[i] && res[i][0] && taken < CDB_WIDTH) begin
        last = i;
        taken++;
      end
    end
    return (last < 0) ? ptr : (last + 1) % NUM_FU;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model state advances on the same edge as the DUT
  always @(posedge clock) begin
    m_live <= 1'b1;
    if (!reset) begin
      m_ptr   <= 0;
      m_slots <= '0;
      m_cnt   <= 0;
    end else begin
      m_ptr   <= exp_ptr(m_ptr, fu_req, fu_result);
      m_slots <= exp_slots(m_ptr, fu_req, fu_result);
      m_cnt   <= $countones(exp_gnt(m_ptr, fu_req, fu_result));
    end
  end

  // Compare process: outputs sampled mid-cycle, away from the active edge
  always @(negedge clock) begin
    if (m_live) begin
      #2;
      chk("fu_gnt", 64'(fu_gnt), reset ? 64'(exp_gnt(m_ptr, fu_req, fu_result)) : 64'd0);
      chk("cdb_count", 64'(cdb_count), 64'(m_cnt));
      for (int k = 0; k < CDB_WIDTH; k++) begin
        chk($sformatf("cdb_out[%0d]", k), 64'(cdb_out[k]), 64'(m_slots[k]));
      end
    end
  end

  task automatic cyc(input logic rst, input logic [NUM_FU-1:0] req, input pkts_t res);
    @(negedge clock);
    reset     = rst;
    fu_req    = req;
    fu_result = res;
    #3;
  endtask

  initial begin
    pkts_t r2;
    pkts_t r3;
    for (int i = 0; i < NUM_FU; i++) base[i] = pkt(32'h1000_0000 + 32'(i), 6'(i + 1), 1'b1);

    // Reset held with every FU requesting
    cyc(1'b0, 4'b1111, base);
    chk("rst_gnt_a", 64'(fu_gnt), 64'd0);
    cyc(1'b0, 4'b1111, base);
    chk("rst_gnt_b", 64'(fu_gnt), 64'd0);
    chk("rst_count", 64'(cdb_count), 64'd0);
    chk("rst_slot0", 64'(cdb_out[0]), 64'd0);
    chk("rst_slot1", 64'(cdb_out[1]), 64'd0);

    // Round-robin with all four requesting
    cyc(1'b1, 4'b1111, base);
    chk("rr_gnt0", 64'(fu_gnt), 64'b0011);
    cyc(1'b1, 4'b1111, base);
    chk("rr_gnt1", 64'(fu_gnt), 64'b1100);
    chk("rr_slot0_a", 64'(cdb_out[0]), 64'(base[0]));
    chk("rr_slot1_a", 64'(cdb_out[1]), 64'(base[1]));
    chk("rr_count", 64'(cdb_count), 64'd2);
    cyc(1'b1, 4'b1111, base);
    chk("rr_gnt2", 64'(fu_gnt), 64'b0011);
    chk("rr_slot0_b", 64'(cdb_out[0]), 64'(base[2]));
    chk("rr_slot1_b", 64'(cdb_out[1]), 64'(base[3]));
    cyc(1'b1, 4'b1111, base);
    chk("rr_gnt3", 64'(fu_gnt), 64'b1100);

    // Single request, pointer now 0
    r2 = base;
    r2[2] = pkt(32'hDEADBEEF, 6'd17, 1'b1);
    cyc(1'b1, 4'b0100, r2);
    chk("single_gnt", 64'(fu_gnt), 64'b0100);

    // Wrap-around from pointer 3
    cyc(1'b1, 4'b1011, base);
    chk("wrap_gnt", 64'(fu_gnt), 64'b1001);
    chk("single_slot0", 64'(cdb_out[0]), 64'(pkt(32'hDEADBEEF, 6'd17, 1'b1)));
    chk("single_slot1", 64'(cdb_out[1]), 64'd0);
    chk("single_count", 64'(cdb_count), 64'd1);
    cyc(1'b1, 4'b0010, base);
    chk("wrap_slot0", 64'(cdb_out[0]), 64'(base[3]));
    chk("wrap_slot1", 64'(cdb_out[1]), 64'(base[0]));
    chk("model_ptr_wrap", 64'(m_ptr), 64'd1);

    // Mult (FU1) loses to FU2, FU0 from pointer 2, then wins while holding its packet
    cyc(1'b1, 4'b0111, base);
    chk("mult_gnt_lose", 64'(fu_gnt), 64'b0101);
    chk("mult_pre_slot0", 64'(cdb_out[0]), 64'(base[1]));
    cyc(1'b1, 4'b0010, base);
    chk("mult_gnt_win", 64'(fu_gnt), 64'b0010);
    chk("mult_alu_slot0", 64'(cdb_out[0]), 64'(base[2]));
    chk("mult_alu_slot1", 64'(cdb_out[1]), 64'(base[0]));

    // Request with an invalid packet is ignored and the pointer holds
    r3 = base;
    r3[3] = pkt(32'h1234_5678, 6'd9, 1'b0);
    cyc(1'b1, 4'b1000, r3);
    chk("inval_gnt_a", 64'(fu_gnt), 64'd0);
    chk("mult_slot0", 64'(cdb_out[0]), 64'(base[1]));
    chk("mult_count", 64'(cdb_count), 64'd1);
    cyc(1'b1, 4'b1000, r3);
    chk("inval_gnt_b", 64'(fu_gnt), 64'd0);
    chk("inval_count", 64'(cdb_count), 64'd0);
    chk("model_ptr_hold", 64'(m_ptr), 64'd2);
    cyc(1'b1, 4'b1111, base);
    chk("inval_after_gnt", 64'(fu_gnt), 64'b1100);

    // Random traffic with occasional invalid packets and mid-operation resets
    repeat (3000) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rr[i] = pkt($urandom, 6'($urandom), 1'($urandom_range(0, 7) != 0));
      end
      cyc(1'($urandom_range(0, 39) != 0), 4'($urandom), rr);
    end

    @(negedge clock);
    #4;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
